// File: rtl/btn_evt_if.sv
// Button event bus: debounced level in, classified press events and mode index out.
// master = event classifier (btn_evt), slave = consumer / stimulus side.
interface btn_evt_if #(
  parameter int MODE_W = 2
);
  logic              sig_i;
  logic              held_o;
  logic              short_o;
  logic              long_o;
  logic              rep_o;
  logic [MODE_W-1:0] mode_o;

  modport master (
    input  sig_i,
    output held_o, short_o, long_o, rep_o, mode_o
  );

  modport slave (
    output sig_i,
    input  held_o, short_o, long_o, rep_o, mode_o
  );
endinterface

// File: rtl/btn_evt.sv
// Classifies debounced button presses into short/long/repeat pulses and a wrapping mode index.
// Optional auto-repeat while long-held is enabled by defining BTN_EVT_REPEAT_EN.
module btn_evt #(
  parameter int CNT_W    = 24,
  parameter int LONG_CYC = 12000000,
  parameter int REP_CYC  = 3000000,
  parameter int NMODES   = 4,
  parameter int MODE_W   = 2
) (
  input  logic      clk,
  input  logic      rst,
  btn_evt_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NMODES - 1);

  if (LONG_CYC < 2 || REP_CYC < 1 || NMODES < 1) begin : g_bad_param
    $error("btn_evt: parameter out of range");
  end

  function automatic logic [MODE_W-1:0] mode_adv(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    if (m == MODE_LAST) begin
      r = {MODE_W{1'b0}};
    end else begin
      r = m + MODE_W'(1'b1);
    end
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [MODE_W-1:0] mode_r, mode_s;
  logic              short_r, short_s;
  logic              long_r, long_s;
  logic              held_r;
`ifdef BTN_EVT_REPEAT_EN
  logic [CNT_W-1:0]  rcnt_r, rcnt_s;
  logic              rep_r, rep_s;
`endif

  // Next-state and next-output decode; pulses default low each cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    short_s = 1'b0;
    long_s  = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
    rcnt_s  = rcnt_r;
    rep_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (bus.sig_i) begin
          state_s = PRESS;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      PRESS: begin
        // Release wins over reaching the threshold on the same edge.
        if (!bus.sig_i) begin
          state_s = IDLE;
          short_s = 1'b1;
          mode_s  = mode_adv(mode_r);
        end else if (cnt_r == LONG_LAST) begin
          state_s = LONG;
          long_s  = 1'b1;
          mode_s  = {MODE_W{1'b0}};
`ifdef BTN_EVT_REPEAT_EN
          rcnt_s  = {CNT_W{1'b0}};
`endif
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      LONG: begin
        if (!bus.sig_i) begin
          state_s = IDLE;
        end else begin
          state_s = LONG;
`ifdef BTN_EVT_REPEAT_EN
          if (rcnt_r == CNT_W'(REP_CYC - 1)) begin
            rep_s  = 1'b1;
            rcnt_s = {CNT_W{1'b0}};
            mode_s = mode_adv(mode_r);
          end else begin
            rcnt_s = rcnt_r + CNT_W'(1'b1);
          end
`endif
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      mode_r  <= {MODE_W{1'b0}};
      short_r <= 1'b0;
      long_r  <= 1'b0;
      held_r  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rcnt_r  <= {CNT_W{1'b0}};
      rep_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      short_r <= short_s;
      long_r  <= long_s;
      held_r  <= (state_s != IDLE);
`ifdef BTN_EVT_REPEAT_EN
      rcnt_r  <= rcnt_s;
      rep_r   <= rep_s;
`endif
    end
  end

  assign bus.held_o  = held_r;
  assign bus.short_o = short_r;
  assign bus.long_o  = long_r;
  assign bus.mode_o  = mode_r;
`ifdef BTN_EVT_REPEAT_EN
  assign bus.rep_o   = rep_r;
`else
  assign bus.rep_o   = 1'b0;
`endif

endmodule

// File: tb/tb_btn_evt.sv
// Scoreboard bench for btn_evt: a press-duration model queues expected outputs per edge.
// Define BTN_EVT_REPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_btn_evt;
  localparam int CNT_W    = 24;
  localparam int LONG_CYC = 8;
  localparam int REP_CYC  = 4;
  localparam int NMODES   = 3;
  localparam int MODE_W   = 2;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  typedef struct packed {
    logic              held;
    logic              short_p;
    logic              long_p;
    logic              rep_p;
    logic [MODE_W-1:0] mode;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_evt_if #(.MODE_W(MODE_W)) bif();

  btn_evt #(
    .CNT_W(CNT_W), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC),
    .NMODES(NMODES), .MODE_W(MODE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_short, n_long, n_rep;
  int   n_held;

  // Model state: press in progress, long reached, edges held since press edge.
  bit   m_active, m_long;
  int   m_h, m_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap_inc(input int m);
    return (m + 1) % NMODES;
  endfunction

  task automatic model_step(input logic s, input logic r);
    obs_t e;
    e = '0;
    if (r) begin
      m_active = 1'b0; m_long = 1'b0; m_h = 0; m_mode = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1; m_long = 1'b0; m_h = 0;
      end
    end else if (!s) begin
      if (!m_long) begin
        e.short_p = 1'b1;
        m_mode = wrap_inc(m_mode);
      end
      m_active = 1'b0; m_long = 1'b0;
    end else begin
      m_h++;
      if (m_h == LONG_CYC) begin
        e.long_p = 1'b1; m_long = 1'b1; m_mode = 0;
      end else if (REP_ON && m_long && ((m_h - LONG_CYC) % REP_CYC == 0)) begin
        e.rep_p = 1'b1;
        m_mode = wrap_inc(m_mode);
      end
    end
    e.held = m_active;
    e.mode = MODE_W'(m_mode);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic s, input logic r);
    obs_t got, e;
    bif.sig_i = s;
    rst = r;
    model_step(s, r);
    @(posedge clk);
    #1;
    got = {bif.held_o, bif.short_o, bif.long_o, bif.rep_o, bif.mode_o};
    e = exp_q.pop_front();
    check("outs", 32'(got), 32'(e));
    n_short += int'(bif.short_o);
    n_long  += int'(bif.long_o);
    n_rep   += int'(bif.rep_o);
    n_held  += int'(bif.held_o);
    @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    for (int i = 0; i < hi; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < lo; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic clr_counts();
    n_short = 0; n_long = 0; n_rep = 0; n_held = 0;
  endtask

  initial begin
    int seq_exp [3];
    int run_len;
    logic lvl;
    seq_exp[0] = 1; seq_exp[1] = 2; seq_exp[2] = 0;
    rst = 1'b1;
    bif.sig_i = 1'b0;
    m_active = 1'b0; m_long = 1'b0; m_h = 0; m_mode = 0;
    clr_counts();
    @(negedge clk);

    // Reset state
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("rst_mode", 32'(bif.mode_o), 32'd0);

    // Three-edge press gives one short
    clr_counts();
    press(3, 3);
    check("t1_short", n_short, 1);
    check("t1_long", n_long, 0);
    check("t1_held", n_held, 3);
    check("t1_mode", 32'(bif.mode_o), 32'd1);

    // Three shorts from mode 0 wrap 1,2,0
    cycle(1'b0, 1'b1);
    clr_counts();
    for (int k = 0; k < 3; k++) begin
      press(2, 2);
      check("t2_mode", 32'(bif.mode_o), 32'(seq_exp[k]));
    end
    check("t2_short", n_short, 3);

    // Release on the threshold edge: short wins
    clr_counts();
    press(LONG_CYC, 3);
    check("t3_short", n_short, 1);
    check("t3_long", n_long, 0);

    // Long press from mode 2, held through edge 20
    press(1, 2);
    check("t4_pre_mode", 32'(bif.mode_o), 32'd2);
    clr_counts();
    for (int i = 0; i <= LONG_CYC; i++) cycle(1'b1, 1'b0);
    check("t4_long_pulse", 32'(bif.long_o), 32'd1);
    check("t4_long_mode", 32'(bif.mode_o), 32'd0);
    press(20 - LONG_CYC, 3);
    check("t4_long", n_long, 1);
    check("t4_short", n_short, 0);
    check("t4_rep", n_rep, REP_ON ? 3 : 0);

    // Reset mid-press at cnt 5 with mode 2
    while (m_mode != 2) press(1, 1);
    clr_counts();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("t5_rst_held", 32'(bif.held_o), 32'd0);
    check("t5_rst_mode", 32'(bif.mode_o), 32'd0);
    cycle(1'b1, 1'b0);
    check("t5_repress", 32'(bif.held_o), 32'd1);
    clr_counts();
    press(LONG_CYC, 2);
    check("t5_long_after_rst", n_long, 1);

    // Re-press on the cycle after release
    clr_counts();
    press(2, 1);
    press(2, 1);
    press(1, 2);
    check("t6_short", n_short, 3);

    // Random press lengths with occasional reset
    for (int k = 0; k < 120; k++) begin
      lvl = k[0];
      run_len = $urandom_range(1, LONG_CYC + 3 * REP_CYC);
      for (int i = 0; i < run_len; i++) begin
        cycle(lvl, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end
    check("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
